// File: rtl/bram_sdp_be_pkg.sv
// Shared constants and helpers for the accelerator buffer-layer RAM models.
// byte_merge works on a maximal width; callers cast to and from their own data width.
package bram_pkg;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;
  localparam int MAX_DW          = 1024;
  localparam int MAX_BE          = MAX_DW / 8;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < n) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  function automatic logic [MAX_DW-1:0] byte_merge(
    input logic [MAX_DW-1:0] old_w,
    input logic [MAX_DW-1:0] new_w,
    input logic [MAX_BE-1:0] be
  );
    logic [MAX_DW-1:0] r;
    r = old_w;
    for (int i = 0; i < MAX_BE; i++) begin
      r[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/bram_sdp_be_out_pipe.sv
// Optional output register stage for the SDP RAM: holds data, passes the valid strobe.
module bram_out_pipe #(
  parameter int DW = 128
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [DW-1:0] d_i,
  input  logic          vld_i,
  output logic [DW-1:0] q_o,
  output logic          vld_o
);

  logic [DW-1:0] q_q;
  logic [DW-1:0] q_d;
  logic          vld_q;

  // Data only advances with a completing read so the output holds otherwise.
  always_comb begin
    if (vld_i) begin
      q_d = d_i;
    end else begin
      q_d = q_q;
    end
  end

  // Stage register with synchronous clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_q   <= '0;
      vld_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      vld_q <= vld_i;
    end
  end

  assign q_o   = q_q;
  assign vld_o = vld_q;

endmodule

// File: rtl/bram_sdp_be.sv
// Simple-dual-port block RAM with byte enables, selectable read-during-write
// behaviour, optional output register and a read-valid strobe.
module bram_sdp_be
  import bram_pkg::*;
#(
  parameter int DW       = 128,
  parameter int WL       = 64,
  parameter int AW       = 13,
  parameter int OUT_REG  = 0,
  parameter int RDW_MODE = RDW_READ_FIRST
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            WEN,
  input  logic [DW/8-1:0] WBE,
  input  logic [AW-1:0]   WA,
  input  logic [DW-1:0]   WD,
  input  logic            REN,
  input  logic [AW-1:0]   RA,
  output logic [DW-1:0]   RD,
  output logic            RVLD
);

  localparam int OFS = clog2(DW / 8);
  localparam int IW  = (clog2(WL) > 0) ? clog2(WL) : 1;

  logic [DW-1:0]     mem_q [WL];
  logic [AW-OFS-1:0] wa_word_s;
  logic [AW-OFS-1:0] ra_word_s;
  logic [IW-1:0]     wa_idx_s;
  logic [IW-1:0]     ra_idx_s;
  logic              wr_ok_s;
  logic              rd_ok_s;
  logic              coll_s;
  logic [DW-1:0]     wr_word_s;
  logic [DW-1:0]     old_rd_s;
  logic [DW-1:0]     merged_rd_s;
  logic [DW-1:0]     rd_d;
  logic [DW-1:0]     rd_q;
  logic              rvld_d;
  logic              rvld_q;
  logic              unused_lsb_s;

  // Sub-word address bits carry no meaning for a word-wide RAM.
  assign unused_lsb_s = ^{WA[OFS-1:0], RA[OFS-1:0]};

  assign wa_word_s = WA[AW-1:OFS];
  assign ra_word_s = RA[AW-1:OFS];
  assign wa_idx_s  = wa_word_s[IW-1:0];
  assign ra_idx_s  = ra_word_s[IW-1:0];
  assign wr_ok_s   = int'(wa_word_s) < WL;
  assign rd_ok_s   = int'(ra_word_s) < WL;
  assign coll_s    = WEN && wr_ok_s && rd_ok_s && (wa_word_s == ra_word_s);

  assign wr_word_s   = DW'(byte_merge(MAX_DW'(mem_q[wa_idx_s]), MAX_DW'(WD), MAX_BE'(WBE)));
  assign old_rd_s    = rd_ok_s ? mem_q[ra_idx_s] : '0;
  assign merged_rd_s = DW'(byte_merge(MAX_DW'(old_rd_s), MAX_DW'(WD), MAX_BE'(WBE)));

  // Read response selection: out-of-range reads return zero, collisions follow RDW_MODE.
  always_comb begin
    rd_d   = rd_q;
    rvld_d = 1'b0;
    if (REN) begin
      rvld_d = 1'b1;
      if (!rd_ok_s) begin
        rd_d = '0;
      end else if (coll_s && (RDW_MODE == RDW_WRITE_FIRST)) begin
        rd_d = merged_rd_s;
      end else begin
        rd_d = old_rd_s;
      end
    end else begin
      rd_d = rd_q;
    end
  end

  // Memory array write; contents survive reset.
  always_ff @(posedge CLK) begin
    if (!RST && WEN && wr_ok_s) begin
      mem_q[wa_idx_s] <= wr_word_s;
    end
  end

  // First read stage: data plus valid.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_q   <= '0;
      rvld_q <= 1'b0;
    end else begin
      rd_q   <= rd_d;
      rvld_q <= rvld_d;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_pipe
      bram_out_pipe #(.DW(DW)) u_pipe (
        .clk_i (CLK),
        .rst_i (RST),
        .d_i   (rd_q),
        .vld_i (rvld_q),
        .q_o   (RD),
        .vld_o (RVLD)
      );
    end else begin : g_direct
      assign RD   = rd_q;
      assign RVLD = rvld_q;
    end
  endgenerate

endmodule

// File: doc/bram_sdp_be.md
Name: bram_sdp_be

Overview:
Parametrised simple-dual-port behavioural block RAM with one write port and one read port on a single clock. It is the generalised successor to the fixed 64x128 macro model.
- Adds per-byte write enables and a configurable read-during-write mode.
- Adds an optional output pipeline register and a read-valid strobe.
- Uses defined out-of-range handling.

It sits under the accelerator's buffer layer, holding tiles and weights for the datapath. It is a simulation and FPGA-inference model only.

Parameters:
- DW, 128: data width in bits; must be a multiple of 8.
- WL, 64: depth in words; need not be a power of two.
- AW, 13: byte-address width of WA/RA.
- OUT_REG, 0: 0 gives 1-cycle read latency; 1 adds an output register for 2-cycle latency.
- RDW_MODE, 0: same-word read/write collision policy; 0 = read-first (old data), 1 = write-first (merged new data).

Ports:
- CLK, input, 1: the block's single clock; all logic is on its rising edge.
- RST, input, 1: synchronous, active-high reset; clears output/valid state only, not memory contents.
- WEN, input, 1: write request this cycle.
- WBE, input, DW/8: byte-lane write enables; bit i covers WD[8i+7:8i].
- WA, input, AW: write byte address; word index = WA >> log2(DW/8).
- WD, input, DW: write data.
- REN, input, 1: read request this cycle.
- RA, input, AW: read byte address; word index = RA >> log2(DW/8).
- RD, output, DW: read data.
- RVLD, output, 1: one-cycle strobe marking RD as the response to a read request.

Behaviour:
- Reset (RST=1 at the CLK edge):
  - RD=0, RVLD=0, pipeline stage cleared.
  - Memory array is untouched.
  - A read or write issued in the same cycle as RST is discarded.
  - A read in flight when RST asserts produces no RVLD pulse.
- Write: at the CLK edge with WEN=1 and word index < WL, each byte lane with WBE[i]=1 takes WD; other lanes keep their old value.
  - WBE all-zero: no change.
  - Word index >= WL: write ignored silently.
- Read, OUT_REG=0: REN=1 at edge N gives RD and RVLD=1 after edge N, i.e. valid during cycle N+1.
- Read, OUT_REG=1: the same result appears one cycle later, with RVLD=1 during cycle N+2.
- RD hold: RD holds its last value when no read completes, and RVLD=0 in that case. Back-to-back reads give RVLD high every cycle at full throughput.
- Out-of-range read (index >= WL): returns all-zero data, with RVLD still asserted.
- Collision: WEN=1 and REN=1 in the same cycle with equal in-range word index.
  - RDW_MODE=0: RD is the word value before the write.
  - RDW_MODE=1: RD is the merged word: WD bytes where WBE=1, old bytes elsewhere.
  - Different word indices: no interaction.
- Address LSBs below log2(DW/8) are ignored; there is no sub-word read alignment.
- No internal state machine beyond the valid pipeline: rvld_s1 -> (optional) rvld_s2.

Decomposition:
- Shared package bram_pkg contains:
  - constants RDW_READ_FIRST=0 and RDW_WRITE_FIRST=1;
  - clog2 function;
  - byte_merge(old, new, be) function, shared with other buffer blocks.
- Sub-module bram_out_pipe: a DW+1-bit register stage (data + valid) with sync reset, instantiated only when OUT_REG=1 via generate.

Test Plan:
1. Reset, then write WA=0x000 with WD=0x00..0F pattern and WBE=all ones; read RA=0x000 -> RVLD pulses at cycle +1 (OUT_REG=0) or +2 (OUT_REG=1) with RD=the pattern; RD holds after RVLD drops.
2. Byte enables: write 0xFF..FF to word 3, then write 0x0 with WBE=0x0F00 -> reading word 3 returns bytes 8-11 zero and all other bytes 0xFF.
3. Collision: word 5 holds 0xAA..AA; same cycle WEN with WD=0x55..55 and WBE=0x00FF, and REN to word 5 -> RDW_MODE=0 gives RD=0xAA..AA, RDW_MODE=1 gives RD=0xAA..AA55..55 (low 8 bytes 0x55); a subsequent read returns the merged value in both modes.
4. Out-of-range with WL=48: write to word index 50 then read word 50 -> RD=0, RVLD=1; words 0-47 are unchanged.
5. Reset mid-read: REN at edge N, RST=1 at edge N+1 (OUT_REG=1) -> no RVLD pulse and RD=0; earlier memory contents remain readable after reset.
6. Streaming: 64 back-to-back reads of addresses 0..63 -> RVLD is high for 64 consecutive cycles with data in address order.
